// File: rtl/systolic_drain.sv
// Purpose : walks a size x size result array in row-major order and streams each word out on a valid/ready port.
// Latency : 2 cycles per element (READ then SEND); a full unstalled drain spans 2*size*size+1 cycles including the DONE pulse.
// Backpr. : send_rdy low holds the FSM in SEND with send_msg/row/col/last frozen; nothing is dropped or repeated.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   out_rdy          array results are valid; one assertion (re-armed by a low cycle in IDLE) starts one drain
//   out_rsel/csel    array row/column select, driven straight from the walk counters
//   b_s_out          array word for the current select, combinational in out_rsel/out_csel
//   send_*           drained word with its coordinates, last flag and valid/ready handshake
//   busy             high from leaving IDLE until returning to it
//   drain_done       one-cycle pulse after the final element is accepted
module systolic_drain #(
    parameter int size  = 4,
    parameter int nbits = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    out_rdy,
    output logic [$clog2(size)-1:0] out_rsel,
    output logic [$clog2(size)-1:0] out_csel,
    input  logic [nbits-1:0]        b_s_out,
    output logic [nbits-1:0]        send_msg,
    output logic [$clog2(size)-1:0] send_row,
    output logic [$clog2(size)-1:0] send_col,
    output logic                    send_last,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic                    busy,
    output logic                    drain_done
);

    localparam int            iw       = $clog2(size);
    localparam logic [iw-1:0] last_idx = iw'(size - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [iw-1:0] row;
    logic [iw-1:0] col;
    logic          armed;
    logic          xfer;

    assign xfer     = (state == SEND) && send_rdy;
    assign out_rsel = row;
    assign out_csel = col;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (out_rdy && armed) state_nxt = READ;
            READ:    state_nxt = SEND;
            SEND:    if (xfer) state_nxt = send_last ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        send_val   = 1'b0;
        busy       = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: ;
            READ: busy = 1'b1;
            SEND: begin
                busy     = 1'b1;
                send_val = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                drain_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Walk counters, arming flag and the output word register
    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            armed     <= 1'b1;
            send_msg  <= '0;
            send_row  <= '0;
            send_col  <= '0;
            send_last <= 1'b0;
        end else begin
            if (state == IDLE) begin
                // A low out_rdy seen while idle re-arms; holding it high after a drain does not restart one.
                if (!out_rdy) begin
                    armed <= 1'b1;
                end
                if (out_rdy && armed) begin
                    row <= '0;
                    col <= '0;
                end
            end

            if (state == READ) begin
                send_msg  <= b_s_out;
                send_row  <= row;
                send_col  <= col;
                send_last <= (row == last_idx) && (col == last_idx);
            end

            if (xfer) begin
                if (send_last) begin
                    armed <= 1'b0;
                end
                // size is a power of two, so the increments wrap naturally at size-1;
                // after the last element both counters land back on (0,0).
                col <= col + 1'b1;
                if (col == last_idx) begin
                    row <= row + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

    localparam int SIZE  = 4;
    localparam int NBITS = 16;
    localparam int IW    = $clog2(SIZE);

    typedef struct packed {
        logic [NBITS-1:0] msg;
        logic [IW-1:0]    row;
        logic [IW-1:0]    col;
        logic             last;
    } elem_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             out_rdy = 1'b0;
    logic [IW-1:0]    out_rsel;
    logic [IW-1:0]    out_csel;
    logic [NBITS-1:0] b_s_out;
    logic [NBITS-1:0] send_msg;
    logic [IW-1:0]    send_row;
    logic [IW-1:0]    send_col;
    logic             send_last;
    logic             send_val;
    logic             send_rdy = 1'b1;
    logic             busy;
    logic             drain_done;

    logic [NBITS-1:0] mem [SIZE][SIZE];
    elem_t            exp_q[$];

    int  errors = 0;
    int  checks = 0;
    int  fires = 0;
    int  done_cnt = 0;
    int  last_busy_run = 0;
    bit  rdy_mode = 1'b0;

    systolic_drain #(.size(SIZE), .nbits(NBITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .out_rdy   (out_rdy),
        .out_rsel  (out_rsel),
        .out_csel  (out_csel),
        .b_s_out   (b_s_out),
        .send_msg  (send_msg),
        .send_row  (send_row),
        .send_col  (send_col),
        .send_last (send_last),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .busy      (busy),
        .drain_done(drain_done)
    );

    // Array model: result word is a pure function of the selects.
    assign b_s_out = mem[out_rsel][out_csel];

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_mode) send_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c] = NBITS'(16 * r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                mem[r][c] = NBITS'($urandom);
    endtask

    // Reference: one drain is every array word, row-major, last flag only on the final corner.
    task automatic push_expected();
        elem_t e;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                e.msg  = mem[r][c];
                e.row  = IW'(r);
                e.col  = IW'(c);
                e.last = (r == SIZE - 1) && (c == SIZE - 1);
                exp_q.push_back(e);
            end
    endtask

    // Starts one drain with a single-cycle out_rdy pulse (preceded by a low cycle to re-arm).
    task automatic start_drain();
        out_rdy = 1'b0;
        tick();
        push_expected();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) timeout_fail(name);
    endtask

    task automatic wait_elem(input string name, input int r, input int c);
        int n = 0;
        while (!(send_val && send_row == IW'(r) && send_col == IW'(c)) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) timeout_fail(name);
    endtask

    // Monitor / scoreboard, sampling on the falling edge.
    initial begin
        elem_t cur;
        elem_t held;
        elem_t exp_e;
        logic  hold_prev   = 1'b0;
        logic  last_fire_d = 1'b0;
        int    busy_run    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev   = 1'b0;
                last_fire_d = 1'b0;
                busy_run    = 0;
            end else begin
                cur = '{msg: send_msg, row: send_row, col: send_col, last: send_last};
                if (hold_prev)
                    check("hold_stable", 64'({send_val, cur}), 64'({1'b1, held}));
                if (drain_done || last_fire_d)
                    check("drain_done_timing", 64'(drain_done), 64'(last_fire_d));
                if (drain_done) done_cnt++;
                if (send_val && send_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got %0h with no element expected", cur);
                    end else begin
                        exp_e = exp_q.pop_front();
                        check("xfer_elem", 64'(cur), 64'(exp_e));
                    end
                    fires++;
                end
                last_fire_d = send_val && send_rdy && send_last;
                hold_prev   = send_val && !send_rdy;
                held        = cur;
                if (busy) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    last_busy_run = busy_run;
                    busy_run      = 0;
                end
            end
        end
    end

    initial begin
        int base_done;
        int base_fires;
        int busy_seen;
        int n;

        fill_pattern();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_val_busy_done", 64'({send_val, busy, drain_done, send_last}), 64'(0));
        check("reset_sel", 64'({out_rsel, out_csel}), 64'(0));
        check("reset_send_word", 64'({send_msg, send_row, send_col}), 64'(0));

        // Basic drain, no backpressure.
        base_done = done_cnt;
        start_drain();
        wait_idle("basic_drain", 300);
        tick();
        check("basic_busy_cycles", 64'(last_busy_run), 64'(2 * SIZE * SIZE + 1));
        check("basic_done_count", 64'(done_cnt - base_done), 64'(1));

        // Backpressure at (1,2) for 5 cycles.
        start_drain();
        wait_elem("bp_reach_1_2", 1, 2);
        send_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 64'({send_val, send_msg, send_row, send_col}),
                  64'({1'b1, NBITS'(18), IW'(1), IW'(2)}));
            tick();
        end
        send_rdy = 1'b1;
        wait_idle("bp_drain", 300);

        // Re-arm: out_rdy held high gives exactly one drain.
        fill_random();
        base_done = done_cnt;
        out_rdy = 1'b0;
        tick();
        push_expected();
        out_rdy = 1'b1;
        tick();
        wait_idle("rearm_first", 300);
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        check("rearm_no_restart", 64'(busy_seen), 64'(0));
        push_expected();
        out_rdy = 1'b0;
        tick();
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        wait_idle("rearm_second", 300);
        check("rearm_done_count", 64'(done_cnt - base_done), 64'(2));

        // Early out_rdy drop after 3 transfers.
        fill_random();
        base_fires = fires;
        out_rdy = 1'b0;
        tick();
        push_expected();
        out_rdy = 1'b1;
        n = 0;
        while (fires < base_fires + 3 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout_fail("early_drop_3_fires");
        out_rdy = 1'b0;
        wait_idle("early_drop_drain", 300);
        check("early_drop_fires", 64'(fires - base_fires), 64'(SIZE * SIZE));

        // Reset during SEND of (2,1), with a transfer firing in the same cycle.
        fill_pattern();
        start_drain();
        wait_elem("rst_reach_2_1", 2, 1);
        rst     = 1'b1;
        out_rdy = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_val_busy", 64'({send_val, busy}), 64'(0));
        check("rst_mid_sel", 64'({out_rsel, out_csel}), 64'(0));
        exp_q.delete();
        push_expected();
        tick();
        check("rst_restart_busy_sel", 64'({busy, out_rsel, out_csel}), 64'({1'b1, IW'(0), IW'(0)}));
        wait_idle("rst_restart_drain", 300);
        out_rdy = 1'b0;
        tick();

        // Random backpressure, 100 drains of random data.
        base_done = done_cnt;
        rdy_mode  = 1'b1;
        for (int d = 0; d < 100; d++) begin
            fill_random();
            start_drain();
            wait_idle("random_drain", 2000);
        end
        rdy_mode = 1'b0;
        send_rdy = 1'b1;
        repeat (3) tick();
        check("random_done_count", 64'(done_cnt - base_done), 64'(100));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 The block SHALL have parameter size, default 4, meaning the array dimension; legal values are powers of two >= 2.
REQ-002 The block SHALL have parameter nbits, default 16, meaning the result word width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port out_rdy, input, 1 bit: array results are valid and held stable.
REQ-006 The block SHALL have port out_rsel, output, $clog2(size) bits: array row select.
REQ-007 The block SHALL have port out_csel, output, $clog2(size) bits: array column select.
REQ-008 The block SHALL have port b_s_out, input, nbits bits: array result, combinational in out_rsel/out_csel.
REQ-009 The block SHALL have port send_msg, output, nbits bits: drained result word.
REQ-010 The block SHALL have port send_row, output, $clog2(size) bits: row index of send_msg.
REQ-011 The block SHALL have port send_col, output, $clog2(size) bits: column index of send_msg.
REQ-012 The block SHALL have port send_last, output, 1 bit: send_msg is the final element, row size-1 and column size-1.
REQ-013 The block SHALL have port send_val, output, 1 bit: send_msg is valid.
REQ-014 The block SHALL have port send_rdy, input, 1 bit: the consumer accepts send_msg.
REQ-015 The block SHALL have port busy, output, 1 bit: a drain is in progress.
REQ-016 The block SHALL have port drain_done, output, 1 bit: single-cycle pulse after the last element is accepted.

Function
REQ-017 The block SHALL implement a four-state FSM: IDLE, READ, SEND, DONE.
REQ-018 In IDLE, the FSM SHALL go to READ on the next edge when out_rdy=1 and armed=1, and SHALL load row=0 and col=0.
REQ-019 out_rsel and out_csel SHALL equal the internal row and col counters at all times.
REQ-020 In READ, the block SHALL register b_s_out, row and col into the send_msg, send_row and send_col registers, and SHALL go to SEND on the next edge.
REQ-021 In SEND, send_val SHALL be 1; in every other state, send_val SHALL be 0.
REQ-022 While in SEND, send_msg, send_row, send_col and send_last SHALL be held stable until the transfer fires.
REQ-023 A transfer SHALL fire on a cycle where send_val=1 and send_rdy=1; the FSM SHALL stay in SEND indefinitely while send_rdy=0.
REQ-024 On a transfer that is not the last, col SHALL increment; when col=size-1, col SHALL wrap to 0 and row SHALL increment (row-major order); the FSM SHALL then go to READ.
REQ-025 On the last transfer, the FSM SHALL go to DONE and SHALL clear armed.
REQ-026 In DONE, drain_done SHALL be 1 for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-027 busy SHALL be 1 in READ, SEND and DONE, and 0 in IDLE.
REQ-028 armed SHALL be set on any cycle where out_rdy=0 and the FSM is in IDLE, so that one out_rdy assertion yields exactly one drain.
REQ-029 Deassertion of out_rdy mid-drain SHALL NOT abort or alter the drain.
REQ-030 Each element SHALL take 2 cycles minimum: READ, then SEND with send_rdy=1; a full drain SHALL take 2*size*size+1 cycles from leaving IDLE until returning to IDLE, with no backpressure.
REQ-031 Data SHALL pass through unmodified, with no truncation, sign change or width change.

Reset
REQ-032 On rst=1 at a clock edge, the FSM SHALL go to IDLE, row and col SHALL go to 0, armed SHALL go to 1, send_msg, send_row and send_col SHALL go to 0, and send_val, send_last, busy and drain_done SHALL go to 0.
REQ-033 rst SHALL take priority over every other event, including a transfer firing in the same cycle.
REQ-034 rst asserted mid-drain SHALL abandon the drain; if out_rdy=1 after reset, a new drain SHALL start from (0,0).

Verification
REQ-035 Basic drain (size=4, array value = 16*r+c, send_rdy=1, one out_rdy pulse) -> 16 transfers with msg 0,1,2,3,16,...,51 in row-major order; send_last only on (3,3); drain_done one cycle later; busy high for 33 cycles.
REQ-036 Backpressure (send_rdy=0 for 5 cycles at element (1,2)) -> send_val held with msg 18, row 1, col 2 stable for all 5 cycles; the next element (1,3)=19 follows after send_rdy returns; no element lost or duplicated.
REQ-037 Re-arm (out_rdy held at 1 throughout) -> exactly one drain; after out_rdy=0 for 1 cycle and then 1 -> a second complete drain.
REQ-038 Early out_rdy drop (out_rdy falls after 3 transfers) -> all 16 transfers still complete.
REQ-039 Reset mid-drain (rst during SEND of element (2,1)) -> next cycle send_val=0, busy=0, out_rsel=out_csel=0; with out_rdy=1 -> a new drain starts at (0,0).
REQ-040 Random send_rdy (50% duty, 100 drains) -> a scoreboard matches all elements in order, and drain_done count equals the number of drains.
